// File: rtl/button_conditioner.sv
// Five-channel board-control conditioner: 2-FF sync, debounce FSM, then level (stop) or press pulse.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses on btn0/btn1.
module button_channel #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_RATE     = 100000,
  parameter bit LEVEL_OUT       = 1'b0,
  parameter bit REPEAT_CAP      = 1'b0
) (
  input  logic clka,
  input  logic rst_n,
  input  logic raw,
  output logic cond
);
`ifdef BTN_AUTOREPEAT_EN
  localparam bit RPT_BUILD = 1'b1;
`else
  localparam bit RPT_BUILD = 1'b0;
`endif
  // Repeat path is constant-false unless both the build and the channel enable it.
  localparam bit RPT_EN = RPT_BUILD && REPEAT_CAP;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;

  state_t           state, state_nxt;
  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt, cnt_nxt, rcnt, rcnt_nxt;
  logic             rep, rep_nxt, pulse, pulse_nxt, level, s;

  assign s = sync[1];

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      state <= RELEASED;
      cnt   <= '0;
      rcnt  <= '0;
      rep   <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rcnt  <= rcnt_nxt;
      rep   <= rep_nxt;
      pulse <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rcnt_nxt  = rcnt;
    rep_nxt   = rep;
    pulse_nxt = 1'b0;
    case (state)
      RELEASED: if (s) begin
        state_nxt = PRESS_CHK;
        cnt_nxt   = '0;
      end
      PRESS_CHK: begin
        if (!s) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          rcnt_nxt  = '0;
          rep_nxt   = 1'b0;
          pulse_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_nxt = RELEASE_CHK;
          cnt_nxt   = '0;
          rcnt_nxt  = '0;
          rep_nxt   = 1'b0;
        end else if (RPT_EN) begin
          // First repeat after REPEAT_DELAY, then every REPEAT_RATE.
          if ((!rep && rcnt == RD_LAST) || (rep && rcnt == RR_LAST)) begin
            pulse_nxt = 1'b1;
            rep_nxt   = 1'b1;
            rcnt_nxt  = '0;
          end else begin
            rcnt_nxt = rcnt + CNT_W'(1);
          end
        end
      end
      RELEASE_CHK: begin
        if (s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          rcnt_nxt  = '0;
          rep_nxt   = 1'b0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign level = (state == PRESSED) || (state == RELEASE_CHK);
  assign cond  = LEVEL_OUT ? level : pulse;
endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_RATE     = 100000
) (
  input  logic clka,
  input  logic rst_n,
  input  logic stop_raw,
  input  logic prgm_raw,
  input  logic pp_raw,
  input  logic btn0_raw,
  input  logic btn1_raw,
  output logic stop,
  output logic prgm,
  output logic pp,
  output logic btn0,
  output logic btn1
);
  localparam int NUM_CH = 5;

  logic [NUM_CH-1:0] raw_vec, cond_vec;

  assign raw_vec = {btn1_raw, btn0_raw, pp_raw, prgm_raw, stop_raw};

  // Channel 0 (stop) is a level; channels 3/4 (btn0/btn1) may auto-repeat.
  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .LEVEL_OUT      (ch == 0),
      .REPEAT_CAP     (ch >= 3)
    ) u_chan (
      .clka (clka),
      .rst_n(rst_n),
      .raw  (raw_vec[ch]),
      .cond (cond_vec[ch])
    );
  end

  assign {btn1, btn0, pp, prgm, stop} = cond_vec;
endmodule

// File: tb/tb_button_conditioner.sv
// Random + directed bench for button_conditioner against a streak-count reference model.
module tb_button_conditioner;
  localparam int DEB = 4;
  localparam int CW  = 8;
  localparam int RD  = 10;
  localparam int RR  = 5;

  logic       clka = 1'b0;
  logic       rst_n;
  logic [4:0] raw;
  logic       stop, prgm, pp, btn0, btn1;
  logic [4:0] outs;

  assign outs = {btn1, btn0, pp, prgm, stop};

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB), .CNT_W(CW), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clka(clka), .rst_n(rst_n),
    .stop_raw(raw[0]), .prgm_raw(raw[1]), .pp_raw(raw[2]),
    .btn0_raw(raw[3]), .btn1_raw(raw[4]),
    .stop(stop), .prgm(prgm), .pp(pp), .btn0(btn0), .btn1(btn1)
  );

  always #5 clka = ~clka;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int scyc    = 0;

  // Reference model: accepted level flips after DEB+1 consecutive disagreeing samples.
  int m_sp0[5], m_sp1[5], m_acc[5], m_pls[5], m_run[5], m_held[5];
  int pcnt[5], first_hi[5];
  int first_lo0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit rep_ch(input int ch);
`ifdef BTN_AUTOREPEAT_EN
    return ch >= 3;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    for (int ch = 0; ch < 5; ch++) begin
      if (!rst_n) begin
        m_sp0[ch] = 0; m_sp1[ch] = 0; m_acc[ch] = 0;
        m_pls[ch] = 0; m_run[ch] = 0; m_held[ch] = 0;
      end else begin
        int s;
        s = m_sp1[ch];
        m_sp1[ch] = m_sp0[ch];
        m_sp0[ch] = int'(raw[ch]);
        m_pls[ch] = 0;
        if (s != m_acc[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == DEB + 1) begin
            m_acc[ch] = s;
            m_run[ch] = 0;
            if (s == 1) begin
              m_pls[ch]  = 1;
              m_held[ch] = 0;
            end
          end
        end else begin
          if (m_acc[ch] == 1 && rep_ch(ch)) begin
            if (m_run[ch] == 0) begin
              m_held[ch]++;
              if (m_held[ch] == RD || (m_held[ch] > RD && (m_held[ch] - RD) % RR == 0))
                m_pls[ch] = 1;
            end else begin
              m_held[ch] = 0;
            end
          end
          m_run[ch] = 0;
        end
      end
    end
  endtask

  task automatic clear_stats();
    scyc = 0;
    first_lo0 = -1;
    for (int ch = 0; ch < 5; ch++) begin
      pcnt[ch] = 0;
      first_hi[ch] = -1;
    end
  endtask

  // One clock: model follows the active edge, DUT is sampled on the falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clka);
      model_edge();
      @(negedge clka);
      cyc++;
      scyc++;
      chk("stop", int'(stop), m_acc[0]);
      chk("prgm", int'(prgm), m_pls[1]);
      chk("pp",   int'(pp),   m_pls[2]);
      chk("btn0", int'(btn0), m_pls[3]);
      chk("btn1", int'(btn1), m_pls[4]);
      for (int ch = 0; ch < 5; ch++) begin
        if (outs[ch]) begin
          pcnt[ch]++;
          if (first_hi[ch] < 0) first_hi[ch] = scyc;
        end
      end
      if (!stop && first_lo0 < 0) first_lo0 = scyc;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    raw   = '0;
    clear_stats();
    step(3);
    chk("reset_outs", int'(outs), 0);
    rst_n = 1'b1;
    step(3);

    // 1: clean pp press
    raw[2] = 1'b1; clear_stats();
    step(20);
    chk("s1_pp_count", pcnt[2], 1);
    chk("s1_pp_latency", first_hi[2], DEB + 3);
    raw[2] = 1'b0; step(10);

    // 2: prgm glitch shorter than debounce
    raw[1] = 1'b1; clear_stats();
    step(3);
    raw[1] = 1'b0;
    step(10);
    chk("s2_prgm_count", pcnt[1], 0);

    // 3: btn0 with a 2-cycle release bounce
    raw[3] = 1'b1; clear_stats();
    step(12);
    raw[3] = 1'b0; step(2);
    raw[3] = 1'b1; step(8);
    raw[3] = 1'b0; step(10);
    chk("s3_btn0_count", pcnt[3], 1);

    // 4: stop level rise and fall latency
    raw[0] = 1'b1; clear_stats();
    step(10);
    chk("s4_stop_rise", first_hi[0], DEB + 3);
    raw[0] = 1'b0; clear_stats();
    step(10);
    chk("s4_stop_fall", first_lo0, DEB + 3);

    // 5: reset in the middle of a pp press
    raw[2] = 1'b1; clear_stats();
    step(3);
    rst_n = 1'b0;
    step(2);
    chk("s5_rst_outs", int'(outs), 0);
    rst_n = 1'b1; clear_stats();
    step(10);
    chk("s5_pp_count", pcnt[2], 1);
    chk("s5_pp_latency", first_hi[2], DEB + 3);
    raw[2] = 1'b0; step(10);

    // 6: btn1 long hold
    raw[4] = 1'b1; clear_stats();
    step(30);
    raw[4] = 1'b0;
    step(10);
    chk("s6_btn1_first", first_hi[4], DEB + 3);
`ifdef BTN_AUTOREPEAT_EN
    chk("s6_btn1_count", pcnt[4], 5);
`else
    chk("s6_btn1_count", pcnt[4], 1);
`endif

    // Simultaneous press on all channels
    raw = 5'b11111; clear_stats();
    step(8);
    for (int ch = 1; ch < 5; ch++) chk("sim_first", first_hi[ch], DEB + 3);
    raw = '0; step(10);

    // Random stimulus with occasional resets
    for (int i = 0; i < 1500; i++) begin
      for (int ch = 0; ch < 5; ch++)
        if ($urandom_range(0, 11) == 0) raw[ch] = ~raw[ch];
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
      end
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
